// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with occupancy count, almost-full/empty thresholds and sticky errors.
// Define FIFO_FWFT_EN for first-word-fall-through read data; otherwise Dout is a registered read.
module sync_fifo_param #(
  parameter int DW = 8,
  parameter int AW = 4,
  parameter int AF_MARGIN = 2,
  parameter int AE_MARGIN = 2
) (
  input  logic          ck,
  input  logic          rst,
  input  logic [DW-1:0] Din,
  input  logic          Wen,
  input  logic          Ren,
  output logic [DW-1:0] Dout,
  output logic          Fempty,
  output logic          Ffull,
  output logic          Aempty,
  output logic          Afull,
  output logic [AW:0]   Count,
  output logic          Ovf,
  output logic          Udf
);
  localparam int DEPTH = 1 << AW;
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count_nxt;
  logic          rd_ok, wr_ok;
  assign rd_ok = Ren & ~Fempty;
  // a read in the same cycle frees the slot, so a write at full still lands
  assign wr_ok = Wen & (~Ffull | rd_ok);
  always_comb count_nxt = Count + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
  always_ff @(posedge ck) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      Count  <= '0;
      Fempty <= 1'b1;
      Ffull  <= 1'b0;
      Aempty <= 1'b1;
      Afull  <= 1'b0;
      Ovf    <= 1'b0;
      Udf    <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + AW'(wr_ok);
      rd_ptr <= rd_ptr + AW'(rd_ok);
      Count  <= count_nxt;
      Fempty <= count_nxt == '0;
      Ffull  <= count_nxt == (AW+1)'(DEPTH);
      Aempty <= count_nxt <= (AW+1)'(AE_MARGIN);
      Afull  <= count_nxt >= (AW+1)'(DEPTH - AF_MARGIN);
      Ovf    <= Ovf | (Wen & ~wr_ok);
      Udf    <= Udf | (Ren & Fempty);
    end
  end
  always_ff @(posedge ck) begin
    if (wr_ok && !rst) mem[wr_ptr] <= Din;
  end
`ifdef FIFO_FWFT_EN
  assign Dout = Fempty ? '0 : mem[rd_ptr];
`else
  always_ff @(posedge ck) begin
    if (rst) Dout <= '0;
    else if (rd_ok) Dout <= mem[rd_ptr];
  end
`endif
endmodule
